two_level_sweep: RTL and testbench

Sequencer that drives an external two-level gate datapath (inputs a, b, c, d; output f) through all 16 input combinations, samples f after a programmable settle delay and assembles the 16-bit truth table. It sits between a host or testbench start/abort handshake and one `two_level` instance. It provides hardware self-test of the gate network and an optional built-in golden comparison.

---
 rtl/two_level_pkg.sv | 7 +
 rtl/two_level_sweep_if.sv | 30 +++
 rtl/two_level_tt_check.sv | 34 +++
 rtl/two_level_sweep.sv | 91 +++++++++
 tb/tb_two_level_sweep.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/two_level_pkg.sv
// two_level_pkg: shared state encoding, widths and golden truth table for the sweep sequencer.
package two_level_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, APPLY = 2'd1, SAMPLE = 2'd2, DONE = 2'd3} state_e;
    localparam int VEC_W = 4;
    localparam int TT_W = 16;
    localparam logic [TT_W-1:0] GOLDEN_TT = 16'hEFFF;
endpackage

// File: rtl/two_level_sweep_if.sv
// two_level_sweep_if: host handshake, datapath drive/sense and result bus of the sweep sequencer.
// pass and mismatch_cnt exist only with TWO_LEVEL_SWEEP_CHECK_EN.
interface two_level_sweep_if;
    import two_level_pkg::*;
    logic            start;
    logic            abort;
    logic            f_i;
    logic [VEC_W-1:0] vec_o;
    logic            busy;
    logic            done;
    logic [TT_W-1:0] tt;
`ifdef TWO_LEVEL_SWEEP_CHECK_EN
    logic            pass;
    logic [4:0]      mismatch_cnt;
`endif
    modport master (
        output start, abort, f_i,
        input  vec_o, busy, done, tt
`ifdef TWO_LEVEL_SWEEP_CHECK_EN
        , input pass, mismatch_cnt
`endif
    );
    modport slave (
        input  start, abort, f_i,
        output vec_o, busy, done, tt
`ifdef TWO_LEVEL_SWEEP_CHECK_EN
        , output pass, mismatch_cnt
`endif
    );
endinterface

// File: rtl/two_level_tt_check.sv
// two_level_tt_check: counts samples that differ from GOLDEN_TT and latches pass at the final sample.
module two_level_tt_check
    import two_level_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe_i,
    input  logic [VEC_W-1:0] idx_i,
    input  logic             f_i,
    input  logic             clear_i,
    output logic [4:0]       mismatch_cnt_o,
    output logic             pass_o
);
    logic [4:0] cnt_q, cnt_d;
    logic       pass_q, pass_d;
    logic       miss;
    always_comb begin
        miss   = strobe_i && (f_i != GOLDEN_TT[idx_i]);
        cnt_d  = clear_i ? 5'd0 : cnt_q + {4'd0, miss};
        // the verdict must include the miss from the last sample, hence cnt_d
        pass_d = clear_i ? 1'b0 : (strobe_i && idx_i == 4'hF) ? (cnt_d == 5'd0) : pass_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pass_q <= pass_d;
        end
    end
    assign mismatch_cnt_o = cnt_q;
    assign pass_o         = pass_q;
endmodule

// File: rtl/two_level_sweep.sv
// two_level_sweep: walks a two-level gate datapath through all 16 inputs and records its truth table.
// Optional golden checker enabled by TWO_LEVEL_SWEEP_CHECK_EN.
module two_level_sweep
    import two_level_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input logic clk,
    input logic rst,
    two_level_sweep_if.slave bus
);
    localparam logic [7:0] RELOAD = 8'(SETTLE - 1);
    state_e           state_q, state_d;
    logic [VEC_W-1:0] idx_q, idx_d, vec_q, vec_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [TT_W-1:0]  tt_q, tt_d;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        case (state_q)
            IDLE: if (bus.start && !bus.abort) begin
                state_d = APPLY;
                idx_d   = '0;
                vec_d   = '0;
                tt_d    = '0;
                cnt_d   = RELOAD;
            end
            APPLY: if (bus.abort) begin
                state_d = IDLE;
                vec_d   = '0;
            end else if (cnt_q != 8'd0) begin
                cnt_d = cnt_q - 8'd1;
            end else begin
                state_d = SAMPLE;
            end
            SAMPLE: if (bus.abort) begin
                state_d = IDLE;
                vec_d   = '0;
            end else begin
                tt_d[idx_q] = bus.f_i;
                if (idx_q == 4'hF) begin
                    state_d = DONE;
                    vec_d   = '0;
                end else begin
                    state_d = APPLY;
                    idx_d   = idx_q + 4'd1;
                    vec_d   = idx_q + 4'd1;
                    cnt_d   = RELOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
        end
    end
    assign bus.vec_o = vec_q;
    assign bus.busy  = (state_q == APPLY) || (state_q == SAMPLE);
    assign bus.done  = state_q == DONE;
    assign bus.tt    = tt_q;
`ifdef TWO_LEVEL_SWEEP_CHECK_EN
    logic strobe, accept;
    assign strobe = (state_q == SAMPLE) && !bus.abort;
    assign accept = (state_q == IDLE) && bus.start && !bus.abort;
    two_level_tt_check u_chk (
        .clk           (clk),
        .rst           (rst),
        .strobe_i      (strobe),
        .idx_i         (idx_q),
        .f_i           (bus.f_i),
        .clear_i       (accept),
        .mismatch_cnt_o(bus.mismatch_cnt),
        .pass_o        (bus.pass)
    );
`endif
endmodule

// File: tb/tb_two_level_sweep.sv
// tb_two_level_sweep: directed bench for two_level_sweep at SETTLE=1 and SETTLE=3.
// Checker outputs are compared only when TWO_LEVEL_SWEEP_CHECK_EN is defined.
module tb_two_level_sweep;
    logic clk = 1'b0;
    logic rst;
    int   mode = 0;
    int   checks = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    two_level_sweep_if bus1();
    two_level_sweep_if bus3();

    // reference gate network: f=0 only at 4'b1100; mode 1/2 force stuck-at faults
    assign bus1.f_i = (mode == 0) ? (bus1.vec_o != 4'hC) : (mode == 1);
    assign bus3.f_i = bus3.vec_o != 4'hC;

    two_level_sweep #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    two_level_sweep #(.SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    task automatic test_reset;
        rst = 1'b1;
        bus1.start = 1'b1; bus1.abort = 1'b0;
        bus3.start = 1'b1; bus3.abort = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus1.busy, bus1.done, bus1.vec_o, bus1.tt} !== 22'd0) begin
            fails++;
            $display("FAIL reset_dut1: got busy=%b done=%b vec=%h tt=%h, want all 0", bus1.busy, bus1.done, bus1.vec_o, bus1.tt);
        end
        checks++;
        if ({bus3.busy, bus3.done, bus3.vec_o, bus3.tt} !== 22'd0) begin
            fails++;
            $display("FAIL reset_dut3: got busy=%b done=%b vec=%h tt=%h, want all 0", bus3.busy, bus3.done, bus3.vec_o, bus3.tt);
        end
`ifdef TWO_LEVEL_SWEEP_CHECK_EN
        checks++;
        if ({bus1.pass, bus1.mismatch_cnt} !== 6'd0) begin
            fails++;
            $display("FAIL reset_chk: got pass=%b cnt=%0d, want 0/0", bus1.pass, bus1.mismatch_cnt);
        end
`endif
        rst = 1'b0;
        bus1.start = 1'b0;
        bus3.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus1.busy !== 1'b0 || bus3.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_nostart: got busy=%b/%b, want 0/0", bus1.busy, bus3.busy);
        end
    endtask

    task automatic test_sweep_correct;
        logic [5:0] got, exp;
        mode = 0;
        bus1.start = 1'b1;
        for (int n = 1; n <= 33; n++) begin
            @(negedge clk);
            bus1.start = 1'b0;
            exp = (n <= 32) ? {2'b10, 4'((n - 1) / 2)} : 6'b01_0000;
            got = {bus1.busy, bus1.done, bus1.vec_o};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL sweep_cycle%0d: got {busy,done,vec}=%b, want %b", n, got, exp);
            end
        end
        checks++;
        if (bus1.tt !== 16'hEFFF) begin
            fails++;
            $display("FAIL sweep_tt: got %h, want efff", bus1.tt);
        end
`ifdef TWO_LEVEL_SWEEP_CHECK_EN
        checks++;
        if (bus1.pass !== 1'b1 || bus1.mismatch_cnt !== 5'd0) begin
            fails++;
            $display("FAIL sweep_chk: got pass=%b cnt=%0d, want 1/0", bus1.pass, bus1.mismatch_cnt);
        end
`endif
        @(negedge clk);
        checks++;
        if (bus1.done !== 1'b0 || bus1.busy !== 1'b0 || bus1.tt !== 16'hEFFF) begin
            fails++;
            $display("FAIL sweep_after: got done=%b busy=%b tt=%h, want 0/0/efff", bus1.done, bus1.busy, bus1.tt);
        end
    endtask

    task automatic run_sweep1(output int n);
        n = 0;
        bus1.start = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            bus1.start = 1'b0;
            if (bus1.done === 1'b1) begin
                n = i;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_stuck;
        int n;
        mode = 1;
        run_sweep1(n);
        checks++;
        if (n != 33 || bus1.tt !== 16'hFFFF) begin
            fails++;
            $display("FAIL stuck1: got done_at=%0d tt=%h, want 33/ffff", n, bus1.tt);
        end
`ifdef TWO_LEVEL_SWEEP_CHECK_EN
        checks++;
        if (bus1.pass !== 1'b0 || bus1.mismatch_cnt !== 5'd1) begin
            fails++;
            $display("FAIL stuck1_chk: got pass=%b cnt=%0d, want 0/1", bus1.pass, bus1.mismatch_cnt);
        end
`endif
        mode = 2;
        run_sweep1(n);
        checks++;
        if (n != 33 || bus1.tt !== 16'h0000) begin
            fails++;
            $display("FAIL stuck0: got done_at=%0d tt=%h, want 33/0000", n, bus1.tt);
        end
`ifdef TWO_LEVEL_SWEEP_CHECK_EN
        checks++;
        if (bus1.pass !== 1'b0 || bus1.mismatch_cnt !== 5'd15) begin
            fails++;
            $display("FAIL stuck0_chk: got pass=%b cnt=%0d, want 0/15", bus1.pass, bus1.mismatch_cnt);
        end
`endif
        mode = 0;
    endtask

    task automatic test_abort;
        int dones = 0;
        int n = 0;
        bus3.start = 1'b1;
        @(negedge clk);
        bus3.start = 1'b0;
        for (int i = 0; i < 200 && bus3.vec_o !== 4'd5; i++) @(negedge clk);
        checks++;
        if (bus3.vec_o !== 4'd5) begin
            fails++;
            $display("FAIL abort_reach: got vec=%h, want 5", bus3.vec_o);
        end
        bus3.abort = 1'b1;
        @(negedge clk);
        bus3.abort = 1'b0;
        checks++;
        if ({bus3.busy, bus3.done, bus3.vec_o} !== 6'd0 || bus3.tt !== 16'h001F) begin
            fails++;
            $display("FAIL abort_state: got busy=%b done=%b vec=%h tt=%h, want 0/0/0/001f", bus3.busy, bus3.done, bus3.vec_o, bus3.tt);
        end
`ifdef TWO_LEVEL_SWEEP_CHECK_EN
        checks++;
        if (bus3.pass !== 1'b0) begin
            fails++;
            $display("FAIL abort_pass: got %b, want 0", bus3.pass);
        end
`endif
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (bus3.done === 1'b1 || bus3.busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            fails++;
            $display("FAIL abort_quiet: got %0d active cycles, want 0", dones);
        end
        bus3.start = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            bus3.start = 1'b0;
            if (bus3.done === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 65 || bus3.tt !== 16'hEFFF) begin
            fails++;
            $display("FAIL abort_restart: got done_at=%0d tt=%h, want 65/efff", n, bus3.tt);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int cnt = 0;
        int d1 = 0;
        int d2 = 0;
        bus1.start = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 50) bus1.start = 1'b0;
            if (bus1.done === 1'b1) begin
                cnt++;
                if (cnt == 1) d1 = i;
                if (cnt == 2) d2 = i;
            end
        end
        checks++;
        if (cnt != 2 || d1 != 33 || d2 - d1 != 34) begin
            fails++;
            $display("FAIL back_to_back: got dones=%0d first=%0d gap=%0d, want 2/33/34", cnt, d1, d2 - d1);
        end
    endtask

    task automatic test_rst_mid;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        for (int i = 0; i < 200 && bus1.vec_o !== 4'd9; i++) @(negedge clk);
        checks++;
        if (bus1.vec_o !== 4'd9) begin
            fails++;
            $display("FAIL rst_reach: got vec=%h, want 9", bus1.vec_o);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus1.busy, bus1.done, bus1.vec_o, bus1.tt} !== 22'd0) begin
            fails++;
            $display("FAIL rst_mid: got busy=%b done=%b vec=%h tt=%h, want all 0", bus1.busy, bus1.done, bus1.vec_o, bus1.tt);
        end
`ifdef TWO_LEVEL_SWEEP_CHECK_EN
        checks++;
        if ({bus1.pass, bus1.mismatch_cnt} !== 6'd0) begin
            fails++;
            $display("FAIL rst_mid_chk: got pass=%b cnt=%0d, want 0/0", bus1.pass, bus1.mismatch_cnt);
        end
`endif
        @(negedge clk);
        checks++;
        if (bus1.done !== 1'b0 || bus1.busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_after: got done=%b busy=%b, want 0/0", bus1.done, bus1.busy);
        end
    endtask

    initial begin
        test_reset();
        test_sweep_correct();
        test_stuck();
        test_abort();
        test_back_to_back();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
